// File: rtl/md_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// Op codes match the E-stage md_op field.
package md_sequencer_pkg;

    localparam logic [2:0] MD_OP_NONE  = 3'd0;
    localparam logic [2:0] MD_OP_MULT  = 3'd1;
    localparam logic [2:0] MD_OP_MULTU = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_DIVU  = 3'd4;
    localparam logic [2:0] MD_OP_MTHI  = 3'd5;
    localparam logic [2:0] MD_OP_MTLO  = 3'd6;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == MD_OP_MULT) || (op == MD_OP_MULTU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational product/quotient unit for the md sequencer.
// Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly.
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        div_b;
    logic [31:0]        q_mag;
    logic [31:0]        r_mag;
    logic [31:0]        q_s;
    logic [31:0]        r_s;
    logic [31:0]        q_u;
    logic [31:0]        r_u;
    logic [31:0]        safe_b;

    assign sa     = {{32{a[31]}}, a};
    assign sb     = {{32{b[31]}}, b};
    assign prod_s = sa * sb;
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign mag_a  = a[31] ? (32'd0 - a) : a;
    assign mag_b  = b[31] ? (32'd0 - b) : b;
    // Keep the dividers defined when b==0; the result is discarded anyway.
    assign div_b  = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign safe_b = (b == 32'd0) ? 32'd1 : b;
    assign q_mag  = mag_a / div_b;
    assign r_mag  = mag_a % div_b;
    assign q_s    = (a[31] ^ b[31]) ? (32'd0 - q_mag) : q_mag;
    assign r_s    = a[31] ? (32'd0 - r_mag) : r_mag;
    assign q_u    = a / safe_b;
    assign r_u    = a % safe_b;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        unique case (op)
            MD_OP_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_OP_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_OP_DIV: begin
                res_hi = r_s;
                res_lo = q_s;
                div0   = (b == 32'd0);
            end
            MD_OP_DIVU: begin
                res_hi = r_u;
                res_lo = q_u;
                div0   = (b == 32'd0);
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
                div0   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div sequencer owning HI/LO.
// Result is captured at start and committed when the down-counter expires.
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_a,
    input  logic [31:0] e_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        start,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES) + 1;

    md_state_e   state;
    md_state_e   state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] lat;
    logic        last;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div0;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_div0;

    md_arith u_arith (
        .op     (e_op),
        .a      (e_a),
        .b      (e_b),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign lat  = is_div_op(e_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
    assign last = (cnt == CW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= MD_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            MD_IDLE: if (start) state_next = MD_RUN;
            MD_RUN:  if (last)  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    always_comb begin
        start     = (state == MD_IDLE) &&
                    (is_mul_op(e_op) || is_div_op(e_op));
        stall_req = (start || busy) && d_md_use;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            busy      <= 1'b0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_div0 <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
        end else if (start) begin
            cnt       <= lat;
            busy      <= 1'b1;
            pend_hi   <= res_hi;
            pend_lo   <= res_lo;
            pend_div0 <= div0;
        end else if (state == MD_RUN) begin
            cnt <= cnt - CW'(1);
            if (last) begin
                busy <= 1'b0;
                // Divide by zero leaves HI/LO untouched.
                if (!pend_div0) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
            end
        end else begin
            if (e_op == MD_OP_MTHI) hi <= e_a;
            if (e_op == MD_OP_MTLO) lo <= e_a;
        end
    end

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: reference model in plain arithmetic,
// completions checked by a monitor watching busy fall.
module tb_md_sequencer;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [2:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        d_md_use;
    logic        busy;
    logic        start;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    md_sequencer #(
        .MULT_CYCLES (MULT_LAT),
        .DIV_CYCLES  (DIV_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .e_op      (e_op),
        .e_a       (e_a),
        .e_b       (e_b),
        .d_md_use  (d_md_use),
        .busy      (busy),
        .start     (start),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: architectural result of an md op on the model HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        longint      la;
        longint      lb;
        longint      q;
        longint      r;
        logic [63:0] p;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        case (op)
            3'd1: begin
                p = 64'(la * lb);
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            3'd3: if (b != 0) begin
                q = la / lb;
                r = la % lb;
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            3'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    // Called at a negedge with the unit idle.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dmd);
        logic md;
        int   lat;
        exp_t e;
        md  = (op >= 3'd1) && (op <= 3'd4);
        lat = (op == 3'd3 || op == 3'd4) ? DIV_LAT : MULT_LAT;
        e_op = op;
        e_a = a;
        e_b = b;
        d_md_use = dmd;
        #1;
        chk("start", {31'd0, start}, {31'd0, md});
        chk("stall_start", {31'd0, stall_req}, {31'd0, md & dmd});
        model(op, a, b);
        if (md) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.lat = lat;
            sb_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        if (md) begin
            for (int i = 0; i < lat; i++) begin
                // Anything offered while running must be ignored.
                e_op = 3'($urandom_range(1, 6));
                e_a  = $urandom;
                e_b  = $urandom;
                #1;
                chk("busy_run", {31'd0, busy}, 32'd1);
                chk("stall_run", {31'd0, stall_req}, {31'd0, dmd});
                chk("start_run", {31'd0, start}, 32'd0);
                @(posedge clk);
                @(negedge clk);
            end
        end
        e_op = 3'd0;
        #1;
        chk("busy_done", {31'd0, busy}, 32'd0);
        if (!md) begin
            chk("hi_mt", hi, m_hi);
            chk("lo_mt", lo, m_lo);
        end
    endtask

    int   run_len = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            run_len   = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) begin
                run_len++;
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("hi_done", hi, e.hi);
                    chk("lo_done", lo, e.lo);
                    chk("busy_len", run_len, e.lat);
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        e_op = 3'd0;
        e_a = 32'd0;
        e_b = 32'd0;
        d_md_use = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        do_op(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        do_op(3'd4, 32'd100, 32'd7, 1'b0);
        do_op(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        do_op(3'd2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        do_op(3'd5, 32'h0000_1234, 32'd0, 1'b0);
        do_op(3'd6, 32'h0000_5678, 32'd0, 1'b0);
        do_op(3'd3, 32'h0000_0040, 32'd0, 1'b1);
        do_op(3'd4, 32'h0000_0040, 32'd0, 1'b0);
        do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(3'd6, 32'hDEAD_BEEF, 32'd0, 1'b1);
        chk("stall_mt", {31'd0, stall_req}, 32'd0);

        // Async reset in the middle of a DIV, with cnt at 4.
        e_op = 3'd3;
        e_a = 32'd1000;
        e_b = 32'd3;
        d_md_use = 1'b0;
        @(posedge clk);
        e_op = 3'd0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("amid_busy", {31'd0, busy}, 32'd0);
        chk("amid_hi", hi, 32'd0);
        chk("amid_lo", lo, 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        do_op(3'd1, 32'h0000_0007, 32'hFFFF_FFFD, 1'b1);

        for (int n = 0; n < 60; n++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            do_op(op, a, b, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("final_hi", hi, m_hi);
        chk("final_lo", lo, m_lo);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
